// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-snooping MMIO UART transmitter with a byte FIFO and a pollable status word.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  output logic        sel,
  output logic [31:0] readdata,
  output logic        txd,
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [31:0]   TXDATA_ADDR = BASE_ADDR;
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [PW-1:0] PTR_ONE     = PW'(1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_ONE    = BW'(1);
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef MMIO_UART_PARITY_EN
  localparam logic [2:0] ST_PARITY     = 3'd4;
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
  localparam logic       PARITY_FLAG   = 1'b1;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
  localparam logic       PARITY_FLAG   = 1'b0;
`endif

  // FIFO storage and pointers
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Transmit FSM and output registers
  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
`ifdef MMIO_UART_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic       is_txdata;
  logic       is_status;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push_req;
  logic       push_ok;
  logic       baud_last;
  logic [7:0] head_byte;
  logic       unused_wdata_hi;

  assign unused_wdata_hi = ^writedata[31:8];

  assign is_txdata = (dataaddr == TXDATA_ADDR);
  assign is_status = (dataaddr == STATUS_ADDR);
  assign sel       = is_txdata | is_status;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign head_byte = fifo_mem[rd_ptr_q];
  assign baud_last = (baud_q == BAUD_LAST);

  // A full FIFO still accepts a byte when the FSM frees a slot on the same edge.
  assign push_req = memwrite & is_txdata;
  assign push_ok  = push_req & (~full | pop);

  always_comb begin
    readdata = '0;
    if (is_status) begin
      readdata = {28'b0, PARITY_FLAG, overflow_q, full, busy_q};
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (memwrite && is_status) begin
      overflow_d = 1'b0;
    end else if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_AFTER_DATA;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit so queued bytes leave without an idle gap.
        if (baud_last) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
    if (pop) begin
      shift_d = head_byte;
    end
  end

`ifdef MMIO_UART_PARITY_EN
  assign parity_d = pop ? ^head_byte : parity_q;
`endif

  // txd is registered from the next state so each bit appears on the edge that enters it.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE) || (count_d != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
`ifdef MMIO_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
`ifdef MMIO_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      fifo_mem[wr_ptr_q] <= writedata[7:0];
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stores into the UART, with a txd frame monitor checked against a queue
// of expected bytes pushed by the stimulus.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int          CPB  = 4;
`ifdef MMIO_UART_PARITY_EN
  localparam int          FRAME = 11 * CPB;
  localparam logic [31:0] PFLAG = 32'h8;
`else
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] PFLAG = 32'h0;
`endif

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic        sel;
  logic [31:0] readdata;
  logic        txd;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
    bit         abort;
  } exp_t;
  exp_t exp_q[$];

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .dataaddr (dataaddr),
    .writedata(writedata),
    .sel      (sel),
    .readdata (readdata),
    .txd      (txd),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 32'h%08h, want 32'h%08h (cyc %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = 32'h%08h (cyc %0d)", name, act, cyc);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit b2b, input bit abort);
    exp_t e;
    e.data  = d;
    e.b2b   = b2b;
    e.abort = abort;
    exp_q.push_back(e);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    memwrite  = 1'b1;
    dataaddr  = addr;
    writedata = data;
    $display("store [%08h] <= %08h (cyc %0d)", addr, data, cyc);
  endtask

  task automatic load(input logic [31:0] addr);
    @(negedge clk);
    memwrite = 1'b0;
    dataaddr = addr;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      memwrite = 1'b0;
      dataaddr = 32'h0000_0000;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 40 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    int b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef MMIO_UART_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Frame monitor: every txd sample of a frame is compared against the expected byte.
  initial begin
    exp_t e;
    int   start_cyc;
    int   prev_start;
    int   mism;
    bit   aborted;
    prev_start = -100000;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || txd !== 1'b0) continue;
      start_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: start bit seen at cyc %0d, want no frame", cyc);
        repeat (FRAME - 1) @(negedge clk);
        continue;
      end
      e       = exp_q[0];
      mism    = 0;
      aborted = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        if (txd !== exp_bit(e.data, k)) mism++;
      end
      exp_q.delete(0);
      if (aborted) begin
        chk($sformatf("frame_%02h_aborted_by_reset", e.data), {31'b0, e.abort}, 32'd1);
        chk($sformatf("frame_%02h_bits_before_abort", e.data), mism, 0);
      end else begin
        chk($sformatf("frame_%02h_bad_samples", e.data), mism, 0);
        chk($sformatf("frame_%02h_not_aborted", e.data), {31'b0, e.abort}, 32'd0);
        if (e.b2b) chk($sformatf("frame_%02h_b2b_start", e.data), start_cyc, prev_start + FRAME);
        prev_start = start_cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    memwrite  = 1'b0;
    dataaddr  = BASE + 32'd4;
    writedata = 32'h0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    chk("t1_txd_reset", {31'b0, txd}, 32'd1);
    chk("t1_busy_reset", {31'b0, busy}, 32'd0);
    chk("t1_status_reset", readdata, PFLAG);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    // 2: single byte 0xA5, first-edge latency and frame length
    store(BASE, 32'h1234_56A5);
    expect_frame(8'hA5, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    chk("t2_txd_at_store_edge", {31'b0, txd}, 32'd1);
    chk("t2_busy_at_store_edge", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("t2_txd_start_bit", {31'b0, txd}, 32'd0);
    repeat (FRAME - 1) @(posedge clk);
    #1;
    chk("t2_busy_last_stop_cycle", {31'b0, busy}, 32'd1);
    chk("t2_txd_last_stop_cycle", {31'b0, txd}, 32'd1);
    @(posedge clk);
    #1;
    chk("t2_busy_after_frame", {31'b0, busy}, 32'd0);
    drain("t2_drain");

    // 3: overrun. The first byte moves straight into the shifter, so the sixth store is the drop.
    store(BASE, 32'h01); expect_frame(8'h01, 1'b0, 1'b0);
    store(BASE, 32'h02); expect_frame(8'h02, 1'b1, 1'b0);
    store(BASE, 32'h03); expect_frame(8'h03, 1'b1, 1'b0);
    store(BASE, 32'h04); expect_frame(8'h04, 1'b1, 1'b0);
    store(BASE, 32'h05); expect_frame(8'h05, 1'b1, 1'b0);
    store(BASE, 32'h06);
    load(BASE + 32'd4);
    chk("t3_status_after_drop", readdata, 32'h7 | PFLAG);
    chk("t3_sel_status", {31'b0, sel}, 32'd1);
    store(BASE + 32'd4, 32'hDEAD_BEEF);
    load(BASE + 32'd4);
    chk("t3_status_after_clear", readdata, 32'h3 | PFLAG);

    // 4: store lands on the edge where STOP pops the next byte from a full FIFO
    idle(FRAME - 8);
    store(BASE, 32'h07); expect_frame(8'h07, 1'b1, 1'b0);
    load(BASE + 32'd4);
    chk("t4_status_full_plus_pop", readdata, 32'h3 | PFLAG);
    drain("t34_drain");
    load(BASE + 32'd4);
    chk("t34_status_idle", readdata, PFLAG);

    // 5: reset during data bit 3 of 0xF0 with another byte still queued
    store(BASE, 32'hF0); expect_frame(8'hF0, 1'b0, 1'b1);
    store(BASE, 32'h3C);
    idle(17);
    #1;
    chk("t5_busy_mid_frame", {31'b0, busy}, 32'd1);
    chk("t5_txd_data_bit3", {31'b0, txd}, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    dataaddr = BASE + 32'd4;
    @(posedge clk);
    #1;
    chk("t5_txd_after_reset_edge", {31'b0, txd}, 32'd1);
    chk("t5_busy_after_reset_edge", {31'b0, busy}, 32'd0);
    chk("t5_status_after_reset_edge", readdata, PFLAG);
    @(negedge clk);
    reset = 1'b0;
    idle(2 * FRAME);
    #1;
    chk("t5_txd_idle_after_abort", {31'b0, txd}, 32'd1);
    chk("t5_busy_idle_after_abort", {31'b0, busy}, 32'd0);
    chk("t5_queue_after_abort", exp_q.size(), 0);

    // 6: foreign and misaligned stores, loads at TXDATA
    store(BASE + 32'd8, 32'h55);
    #1;
    chk("t6_sel_base8", {31'b0, sel}, 32'd0);
    chk("t6_readdata_base8", readdata, 32'h0);
    store(BASE + 32'd5, 32'h66);
    #1;
    chk("t6_sel_misaligned", {31'b0, sel}, 32'd0);
    load(BASE);
    chk("t6_sel_txdata_load", {31'b0, sel}, 32'd1);
    chk("t6_readdata_txdata_load", readdata, 32'h0);
    load(BASE);
    load(BASE + 32'd4);
    chk("t6_status_after_loads", readdata, PFLAG);
    idle(2 * FRAME);
    #1;
    chk("t6_txd_quiet", {31'b0, txd}, 32'd1);
    chk("t6_busy_quiet", {31'b0, busy}, 32'd0);

    drain("final_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
